// File: rtl/uart_frame_sender.sv
// Buffers FRAME_WORDS 16-bit samples, then sends them to a byte-wide UART
// transmitter as header, little-endian sample bytes and an XOR checksum.
module uart_frame_sender #(
    parameter int unsigned FRAME_WORDS = 16,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_en,
    input  logic [15:0] i_wr_data,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_byte,
    input  logic        i_tx_busy,
    input  logic        i_tx_done,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_overflow
);

    localparam int unsigned IW = $clog2(FRAME_WORDS) + 1;
    localparam int unsigned AW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned PW = $clog2(2 * FRAME_WORDS + 2);
    localparam logic [PW-1:0] LAST_PTR = PW'(2 * FRAME_WORDS + 1);
    localparam logic [IW-1:0] FULL_M1  = IW'(FRAME_WORDS - 1);
    localparam logic [AW-1:0] LAST_RD  = AW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        FILL,
        SEND_REQ,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t        state;
    logic [15:0]   mem [FRAME_WORDS];
    logic [IW-1:0] wr_idx;
    logic [PW-1:0] byte_ptr;
    logic [AW-1:0] rd_idx;
    logic          hi_sel;
    logic [7:0]    csum;
    logic [15:0]   rd_sample;
    logic [7:0]    cur_byte;
    logic          is_data;

    // Sample storage is never cleared; only the index is reset between frames.
    always_ff @(posedge i_clk) begin
        if (state == FILL && i_wr_en) begin
            mem[wr_idx[AW-1:0]] <= i_wr_data;
        end
    end

    always_comb begin
        rd_sample = mem[rd_idx];
        is_data   = (byte_ptr != '0) && (byte_ptr != LAST_PTR);
        if (byte_ptr == '0) begin
            cur_byte = HEADER_BYTE;
        end else if (byte_ptr == LAST_PTR) begin
            cur_byte = csum;
        end else begin
            cur_byte = hi_sel ? rd_sample[15:8] : rd_sample[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= FILL;
            wr_idx       <= '0;
            byte_ptr     <= '0;
            rd_idx       <= '0;
            hi_sel       <= 1'b0;
            csum         <= '0;
            o_tx_start   <= 1'b0;
            o_tx_byte    <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            o_tx_start   <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_wr_en && o_busy) begin
                o_overflow <= 1'b1;
            end
            case (state)
                FILL: begin
                    if (i_wr_en) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_idx == FULL_M1) begin
                            state  <= SEND_REQ;
                            o_busy <= 1'b1;
                        end
                    end
                end
                SEND_REQ: begin
                    if (!i_tx_busy) begin
                        o_tx_start <= 1'b1;
                        o_tx_byte  <= cur_byte;
                        if (is_data) begin
                            csum <= csum ^ cur_byte;
                        end
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_tx_done) begin
                        if (byte_ptr == LAST_PTR) begin
                            state        <= FINISH;
                            o_frame_done <= 1'b1;
                        end else begin
                            byte_ptr <= byte_ptr + 1'b1;
                            state    <= SEND_REQ;
                            // Sample read pointer moves on after the high byte.
                            if (is_data) begin
                                hi_sel <= ~hi_sel;
                                if (hi_sel && rd_idx != LAST_RD) begin
                                    rd_idx <= rd_idx + 1'b1;
                                end
                            end
                        end
                    end
                end
                FINISH: begin
                    o_busy   <= 1'b0;
                    wr_idx   <= '0;
                    csum     <= '0;
                    byte_ptr <= '0;
                    rd_idx   <= '0;
                    hi_sel   <= 1'b0;
                    state    <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: doc/uart_frame_sender.md
UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 Parameter FRAME_WORDS, default 16: number of 16-bit samples per frame, range 1..256.
REQ-002 Parameter HEADER_BYTE, default 8'hA5: first byte sent in every frame.
REQ-003 i_clk  input  1  system clock; all state changes on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous reset, active-low.
REQ-005 i_wr_en  input  1  sample write strobe, one sample per cycle.
REQ-006 i_wr_data  input  16  sample value written when i_wr_en is high.
REQ-007 o_tx_start  output  1  one-cycle start request to the UART transmitter.
REQ-008 o_tx_byte  output  8  byte to transmit; held stable from o_tx_start until i_tx_done.
REQ-009 i_tx_busy  input  1  transmitter transfer-state flag; high while a byte is in flight.
REQ-010 i_tx_done  input  1  transmitter one-cycle done pulse, issued at the end of the stop bit.
REQ-011 o_busy  output  1  high from frame-full until the last byte's i_tx_done.
REQ-012 o_frame_done  output  1  one-cycle pulse after the final byte of a frame completes.
REQ-013 o_overflow  output  1  sticky flag for a write attempted while o_busy is high.

Function
REQ-014 Internal buffer SHALL hold FRAME_WORDS x 16 bits, with a write index of width clog2(FRAME_WORDS)+1.
REQ-015 In FILL, each i_wr_en SHALL store i_wr_data at the write index and increment the index.
REQ-016 When the write index reaches FRAME_WORDS, the block SHALL raise o_busy on the next cycle and enter SEND.
REQ-017 While o_busy is high, i_wr_en SHALL not modify the buffer; o_overflow SHALL be set and held until reset.
REQ-018 Byte order per frame SHALL be: HEADER_BYTE, then for k=0..FRAME_WORDS-1 sample[k][7:0] and sample[k][15:8], then checksum; total 2*FRAME_WORDS+2 bytes.
REQ-019 The checksum SHALL be the 8-bit XOR of all 2*FRAME_WORDS data bytes, excluding the header, accumulated as each data byte is issued.
REQ-020 States: FILL -> SEND_REQ -> WAIT_DONE -> (SEND_REQ | FINISH) -> FILL.
REQ-021 SEND_REQ SHALL assert o_tx_start for exactly one cycle, only when i_tx_busy is low; otherwise it SHALL hold in SEND_REQ.
REQ-022 o_tx_byte SHALL be valid in the same cycle as o_tx_start and SHALL remain unchanged through WAIT_DONE.
REQ-023 WAIT_DONE SHALL ignore all inputs except i_tx_done; on i_tx_done it SHALL advance the byte pointer and go to SEND_REQ, or to FINISH after the checksum byte.
REQ-024 The next o_tx_start SHALL NOT occur earlier than the cycle after the cycle in which i_tx_done is sampled high.
REQ-025 FINISH SHALL pulse o_frame_done for one cycle, clear o_busy, clear the write index and checksum, and return to FILL.
REQ-026 An i_wr_en in the FINISH cycle SHALL be ignored and flagged as overflow; writes are accepted from the first FILL cycle onward.
REQ-027 A spurious i_tx_done outside WAIT_DONE SHALL have no effect.
REQ-028 Buffer contents SHALL not be cleared between frames; only the index is reset.

Reset
REQ-029 When i_rst_n is low, the block SHALL asynchronously force state FILL and clear the write index, byte pointer and checksum.
REQ-030 The same reset SHALL drive o_tx_start=0, o_tx_byte=8'h00, o_busy=0, o_frame_done=0 and o_overflow=0.
REQ-031 Reset asserted mid-frame SHALL abort transmission immediately, and no further o_tx_start SHALL occur until a new full frame is written.
REQ-032 Buffer RAM contents need not be reset.

Verification
REQ-033 Write samples 0x0100..0x010F, with the transmitter model returning done 10 cycles after each start -> 34 bytes: A5, 00 01 01 01 ... 0F 01, checksum 0x00; one o_frame_done pulse.
REQ-034 FRAME_WORDS=2, samples 0x1234 and 0xABCD -> bytes A5 34 12 CD AB, then checksum 0x34^0x12^0xCD^0xAB = 0x40.
REQ-035 Hold i_tx_busy high for 50 cycles at the first SEND_REQ -> no o_tx_start until busy falls, then exactly one start pulse.
REQ-036 Pulse i_wr_en three times while o_busy is high -> o_overflow=1 and frame bytes unchanged; after o_frame_done, a new frame is accepted and o_overflow is still 1.
REQ-037 Assert i_rst_n low during byte 7 of a frame -> all outputs reach reset values in the same cycle; the next full frame transmits correctly from HEADER_BYTE.
REQ-038 Inject i_tx_done during FILL and back-to-back frames -> no effect in FILL; minimum gap of 1 idle cycle between i_tx_done and the next o_tx_start.
